spu32_cpu_alu_ext: RTL and testbench



---
 rtl/spu32_cpu_alu_ext.sv | 218 +++++++++++++++++++++
 tb/tb_spu32_cpu_alu_ext.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spu32_cpu_alu_ext.sv
// spu32_cpu_alu_ext - integer ALU for the spu32 execute stage.
//
// Single-cycle add/sub/logic/compare ops, a barrel or one-bit-per-cycle
// shifter (SHIFT_MULTICYCLE) and an iterative restoring divider resolving
// DIV_BITS quotient bits per cycle. Multi-cycle ops raise O_busy.
//
// Ports:
//   I_clk            clock, rising edge
//   I_reset_n        asynchronous active-low reset
//   I_en             accept strobe for I_aluop (ignored while busy)
//   I_aluop[3:0]     0 ADD 1 SUB 2 AND 3 OR 4 XOR 5 SLT 6 SLTU 7 SLL 8 SRL
//                    9 SRA 10 DIV 11 DIVU 12 REM 13 REMU, 14/15 act as ADD
//   I_dataS1         operand 1 / dividend
//   I_dataS2         operand 2 / divisor / shift amount (low bits)
//   O_data           registered result
//   O_busy           multi-cycle op in progress
//   O_loadstore_adr  combinational S1+S2
//   O_lt/O_ltu/O_eq  combinational signed-less, unsigned-less, equal
module spu32_cpu_alu_ext #(
    parameter int XLEN             = 32,
    parameter int SHIFT_MULTICYCLE = 0,
    parameter int DIV_BITS         = 1
) (
    input  logic            I_clk,
    input  logic            I_reset_n,
    input  logic            I_en,
    input  logic [3:0]      I_aluop,
    input  logic [XLEN-1:0] I_dataS1,
    input  logic [XLEN-1:0] I_dataS2,
    output logic [XLEN-1:0] O_data,
    output logic            O_busy,
    output logic [XLEN-1:0] O_loadstore_adr,
    output logic            O_lt,
    output logic            O_ltu,
    output logic            O_eq
);

    localparam int SHW = $clog2(XLEN);
    localparam int CW  = SHW + 1;
    localparam logic [CW-1:0]   DIV_ITERS = CW'(XLEN / DIV_BITS);
    localparam logic [XLEN-1:0] MOST_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [3:0] OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_AND = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3,  OP_XOR  = 4'd4,  OP_SLT = 4'd5;
    localparam logic [3:0] OP_SLTU = 4'd6,  OP_SLL  = 4'd7,  OP_SRL = 4'd8;
    localparam logic [3:0] OP_SRA  = 4'd9,  OP_DIV  = 4'd10, OP_DIVU = 4'd11;
    localparam logic [3:0] OP_REM  = 4'd12, OP_REMU = 4'd13;

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DIV, ST_FIX} state_t;

    // Two's-complement negate when neg is set; used both to take operand
    // magnitudes and to restore result signs.
    function automatic logic [XLEN-1:0] apply_sign(input logic [XLEN-1:0] mag,
                                                   input logic            neg);
        return neg ? (~mag + 1'b1) : mag;
    endfunction

    state_t            r_state, w_next_state;
    logic [XLEN-1:0]   r_data;
    logic [CW-1:0]     r_cnt;
    logic [3:0]        r_op;
    logic [XLEN-1:0]   r_quo, r_rem, r_div;
    logic              r_neg_q, r_neg_r;

    logic [XLEN:0]     w_sub;
    logic [SHW-1:0]    w_shamt;
    logic              w_is_shift, w_is_div, w_signed_div;
    logic              w_div_zero, w_div_ovf;
    logic              w_start_shift, w_start_div;
    logic              w_s1_neg, w_s2_neg;
    logic [XLEN-1:0]   w_s1_mag, w_s2_mag;
    logic [XLEN-1:0]   w_alu_res, w_shift_step, w_fix_res;
    logic [XLEN-1:0]   w_quo_n, w_rem_n;
    logic [XLEN:0]     w_trial;

    // Compare/address: one XLEN+1-bit subtract, borrow gives unsigned less.
    assign w_sub           = {1'b0, I_dataS1} - {1'b0, I_dataS2};
    assign O_ltu           = w_sub[XLEN];
    assign O_lt            = w_sub[XLEN] ^ (I_dataS1[XLEN-1] ^ I_dataS2[XLEN-1]);
    assign O_eq            = (I_dataS1 == I_dataS2);
    assign O_loadstore_adr = I_dataS1 + I_dataS2;
    assign O_data          = r_data;

    assign w_shamt      = I_dataS2[SHW-1:0];
    assign w_is_shift   = (SHIFT_MULTICYCLE != 0) &&
                          ((I_aluop == OP_SLL) || (I_aluop == OP_SRL) || (I_aluop == OP_SRA));
    assign w_is_div     = (I_aluop == OP_DIV) || (I_aluop == OP_DIVU) ||
                          (I_aluop == OP_REM) || (I_aluop == OP_REMU);
    assign w_signed_div = (I_aluop == OP_DIV) || (I_aluop == OP_REM);
    assign w_div_zero   = (I_dataS2 == '0);
    assign w_div_ovf    = w_signed_div && (I_dataS1 == MOST_NEG) && (I_dataS2 == '1);

    // Divide special cases never start the iterative unit.
    assign w_start_shift = (r_state == ST_IDLE) && I_en && w_is_shift;
    assign w_start_div   = (r_state == ST_IDLE) && I_en && w_is_div && !w_div_zero && !w_div_ovf;

    assign w_s1_neg = w_signed_div && I_dataS1[XLEN-1];
    assign w_s2_neg = w_signed_div && I_dataS2[XLEN-1];
    assign w_s1_mag = apply_sign(I_dataS1, w_s1_neg);
    assign w_s2_mag = apply_sign(I_dataS2, w_s2_neg);

    always_comb begin
        w_alu_res = I_dataS1 + I_dataS2;
        case (I_aluop)
            OP_SUB:  w_alu_res = w_sub[XLEN-1:0];
            OP_AND:  w_alu_res = I_dataS1 & I_dataS2;
            OP_OR:   w_alu_res = I_dataS1 | I_dataS2;
            OP_XOR:  w_alu_res = I_dataS1 ^ I_dataS2;
            OP_SLT:  w_alu_res = {{(XLEN-1){1'b0}}, O_lt};
            OP_SLTU: w_alu_res = {{(XLEN-1){1'b0}}, O_ltu};
            OP_SLL:  w_alu_res = I_dataS1 << w_shamt;
            OP_SRL:  w_alu_res = I_dataS1 >> w_shamt;
            OP_SRA:  w_alu_res = $unsigned($signed(I_dataS1) >>> w_shamt);
            // Only the special cases reach here for divide ops.
            OP_DIV, OP_DIVU: w_alu_res = w_div_zero ? '1 : MOST_NEG;
            OP_REM, OP_REMU: w_alu_res = w_div_zero ? I_dataS1 : '0;
            default: w_alu_res = I_dataS1 + I_dataS2;
        endcase
    end

    always_comb begin
        case (r_op)
            OP_SLL:  w_shift_step = {r_data[XLEN-2:0], 1'b0};
            OP_SRL:  w_shift_step = {1'b0, r_data[XLEN-1:1]};
            default: w_shift_step = {r_data[XLEN-1], r_data[XLEN-1:1]};
        endcase
    end

    // DIV_BITS restoring steps per cycle; the dividend shifts out of r_quo
    // MSB-first while quotient bits shift in at the bottom.
    always_comb begin
        w_rem_n = r_rem;
        w_quo_n = r_quo;
        w_trial = '0;
        for (int k = 0; k < DIV_BITS; k++) begin
            w_trial = {w_rem_n, w_quo_n[XLEN-1]};
            w_quo_n = {w_quo_n[XLEN-2:0], 1'b0};
            if (w_trial >= {1'b0, r_div}) begin
                w_trial    = w_trial - {1'b0, r_div};
                w_quo_n[0] = 1'b1;
            end
            w_rem_n = w_trial[XLEN-1:0];
        end
    end

    assign w_fix_res = ((r_op == OP_DIV) || (r_op == OP_DIVU)) ?
                       apply_sign(r_quo, r_neg_q) : apply_sign(r_rem, r_neg_r);

    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) r_state <= ST_IDLE;
        else            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_shift)    w_next_state = ST_SHIFT;
                else if (w_start_div) w_next_state = ST_DIV;
            end
            ST_SHIFT: if (r_cnt == '0) w_next_state = ST_IDLE;
            ST_DIV:   if (r_cnt == CW'(1)) w_next_state = ST_FIX;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        O_busy = (r_state != ST_IDLE);
    end

    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            r_data  <= '0;
            r_cnt   <= '0;
            r_op    <= '0;
            r_quo   <= '0;
            r_rem   <= '0;
            r_div   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start_shift) begin
                        r_data <= I_dataS1;
                        r_cnt  <= {1'b0, w_shamt};
                        r_op   <= I_aluop;
                    end else if (w_start_div) begin
                        r_quo   <= w_s1_mag;
                        r_div   <= w_s2_mag;
                        r_rem   <= '0;
                        r_cnt   <= DIV_ITERS;
                        r_op    <= I_aluop;
                        r_neg_q <= w_s1_neg ^ w_s2_neg;
                        r_neg_r <= w_s1_neg;
                    end else if (I_en) begin
                        r_data <= w_alu_res;
                    end
                end
                ST_SHIFT: begin
                    if (r_cnt != '0) begin
                        r_data <= w_shift_step;
                        r_cnt  <= r_cnt - 1'b1;
                    end
                end
                ST_DIV: begin
                    r_quo <= w_quo_n;
                    r_rem <= w_rem_n;
                    r_cnt <= r_cnt - 1'b1;
                end
                default: begin
                    r_data <= w_fix_res;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spu32_cpu_alu_ext.sv
module tb_spu32_cpu_alu_ext;

    localparam logic [31:0] MIN = 32'h8000_0000;

    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  busy;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [3:0]  aluop = '0;
    logic [31:0] s1_i = '0;
    logic [31:0] s2_i = '0;

    logic [31:0] data_o [3];
    logic [31:0] adr_o  [3];
    logic        busy_o [3];
    logic        lt_o   [3];
    logic        ltu_o  [3];
    logic        eq_o   [3];

    exp_t exp_q [3][$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    // 0: defaults, 1: multicycle shifter, 2: two quotient bits per cycle
    spu32_cpu_alu_ext #(.XLEN(32), .SHIFT_MULTICYCLE(0), .DIV_BITS(1)) u_dut0 (
        .I_clk(clk), .I_reset_n(rst_n), .I_en(en), .I_aluop(aluop),
        .I_dataS1(s1_i), .I_dataS2(s2_i), .O_data(data_o[0]), .O_busy(busy_o[0]),
        .O_loadstore_adr(adr_o[0]), .O_lt(lt_o[0]), .O_ltu(ltu_o[0]), .O_eq(eq_o[0]));
    spu32_cpu_alu_ext #(.XLEN(32), .SHIFT_MULTICYCLE(1), .DIV_BITS(1)) u_dut1 (
        .I_clk(clk), .I_reset_n(rst_n), .I_en(en), .I_aluop(aluop),
        .I_dataS1(s1_i), .I_dataS2(s2_i), .O_data(data_o[1]), .O_busy(busy_o[1]),
        .O_loadstore_adr(adr_o[1]), .O_lt(lt_o[1]), .O_ltu(ltu_o[1]), .O_eq(eq_o[1]));
    spu32_cpu_alu_ext #(.XLEN(32), .SHIFT_MULTICYCLE(0), .DIV_BITS(2)) u_dut2 (
        .I_clk(clk), .I_reset_n(rst_n), .I_en(en), .I_aluop(aluop),
        .I_dataS1(s1_i), .I_dataS2(s2_i), .O_data(data_o[2]), .O_busy(busy_o[2]),
        .O_loadstore_adr(adr_o[2]), .O_lt(lt_o[2]), .O_ltu(ltu_o[2]), .O_eq(eq_o[2]));

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Reference result from RV32 arithmetic rules.
    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        case (op)
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return {31'b0, sa < sb};
            4'd6:  return {31'b0, a < b};
            4'd7:  return a << b[4:0];
            4'd8:  return a >> b[4:0];
            4'd9:  return sa >>> b[4:0];
            4'd10: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MIN && b == 32'hFFFF_FFFF) return MIN;
                return sa / sb;
            end
            4'd11: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'd12: begin
                if (b == 0) return a;
                if (a == MIN && b == 32'hFFFF_FFFF) return 32'h0;
                return sa % sb;
            end
            4'd13: return (b == 0) ? a : a % b;
            default: return a + b;
        endcase
    endfunction

    // Busy cycles each instance should show for an operation.
    function automatic int exp_busy(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bit div_op, special;
        div_op  = (op >= 4'd10) && (op <= 4'd13);
        special = (b == 0) || ((op == 4'd10 || op == 4'd12) && a == MIN && b == 32'hFFFF_FFFF);
        if (div_op && !special) return (i == 2) ? 17 : 33;
        if (i == 1 && op >= 4'd7 && op <= 4'd9) return int'(b[4:0]) + 1;
        return 0;
    endfunction

    function automatic bit any_busy();
        return busy_o[0] || busy_o[1] || busy_o[2];
    endfunction

    // Scoreboard monitor for one instance: tracks accepts and busy length,
    // compares the result when the instance goes idle after an accept.
    task automatic monitor(input int i);
        bit   prev_busy, pending;
        int   bcnt;
        exp_t e;
        prev_busy = 0;
        pending   = 0;
        bcnt      = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                if (pending && exp_q[i].size() > 0) e = exp_q[i].pop_front();
                pending   = 0;
                prev_busy = 0;
            end else begin
                #1;
                if (!pending && en && !prev_busy) begin
                    pending = 1;
                    bcnt    = 0;
                end
                if (pending) begin
                    if (busy_o[i]) bcnt++;
                    else begin
                        if (exp_q[i].size() == 0) begin
                            n_checks++;
                            n_errors++;
                            $display("FAIL dut%0d_unexpected_result: got %h with no expectation", i, data_o[i]);
                        end else begin
                            e = exp_q[i].pop_front();
                            chk($sformatf("dut%0d_data", i), 64'(data_o[i]), 64'(e.data));
                            chk($sformatf("dut%0d_busy_cycles", i), 64'(bcnt), 64'(e.busy));
                        end
                        pending = 0;
                    end
                end
                prev_busy = busy_o[i];
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);
    initial monitor(2);

    // Issue one op at a negedge, wait for all instances to finish.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input bit toggle);
        logic [31:0] r;
        int          cyc;
        bit          do_toggle;
        exp_t        e;
        r = model(op, a, b);
        do_toggle = toggle && (exp_busy(2, op, a, b) > 10);
        aluop = op;
        s1_i  = a;
        s2_i  = b;
        en    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            e.data = r;
            e.busy = 8'(exp_busy(i, op, a, b));
            exp_q[i].push_back(e);
        end
        #1;
        for (int i = 0; i < 3; i++)
            chk($sformatf("dut%0d_comb_adr_lt_ltu_eq", i),
                {29'b0, adr_o[i], lt_o[i], ltu_o[i], eq_o[i]},
                {29'b0, a + b, $signed(a) < $signed(b), a < b, a == b});
        @(negedge clk);
        en  = 1'b0;
        cyc = 0;
        while (any_busy()) begin
            if (cyc >= 300) begin
                n_checks++;
                n_errors++;
                $display("FAIL busy_timeout: busy still 1 after %0d cycles, required to drop", cyc);
                break;
            end
            if (do_toggle && cyc < 10) begin
                en    = 1'($urandom);
                aluop = 4'($urandom);
                s1_i  = $urandom;
                s2_i  = $urandom;
            end else begin
                en = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        en = 1'b0;
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] a, b;

        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("dut%0d_reset_data", i), 64'(data_o[i]), 64'h0);
            chk($sformatf("dut%0d_reset_busy", i), 64'(busy_o[i]), 64'h0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        issue(4'd0,  32'hFFFF_FFFF, 32'h1, 0);
        issue(4'd10, 32'hFFFF_FFF9, 32'h2, 0);
        issue(4'd12, 32'hFFFF_FFF9, 32'h2, 0);
        issue(4'd11, 32'd100, 32'h0, 0);
        issue(4'd12, MIN, 32'hFFFF_FFFF, 0);
        issue(4'd10, MIN, 32'hFFFF_FFFF, 0);
        issue(4'd9,  MIN, 32'd4, 0);
        issue(4'd7,  32'h1234_5678, 32'h0, 0);
        issue(4'd8,  32'hF000_000F, 32'd31, 0);
        issue(4'd11, 32'hFFFF_FFFF, 32'h10, 1);
        issue(4'd13, 32'hDEAD_BEEF, 32'h1234, 1);
        issue(4'd14, 32'd7, 32'd9, 0);
        issue(4'd15, 32'hFFFF_FFFE, 32'd3, 0);
        issue(4'd5,  32'h8000_0001, 32'h1, 0);
        issue(4'd6,  32'h8000_0001, 32'h1, 0);

        for (int n = 0; n < 150; n++) begin
            op = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 7))
                0: a = MIN;
                1: a = 32'hFFFF_FFFF;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0: b = 32'h0;
                1: b = 32'hFFFF_FFFF;
                2: b = 32'($urandom_range(1, 40));
                default: b = $urandom;
            endcase
            issue(op, a, b, 1'($urandom));
        end

        // Abort a divide with an asynchronous reset mid-cycle.
        aluop = 4'd10;
        s1_i  = 32'h0001_0000;
        s2_i  = 32'd3;
        en    = 1'b1;
        @(negedge clk);
        en = 1'b0;
        repeat (9) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("dut%0d_abort_busy", i), 64'(busy_o[i]), 64'h0);
            chk($sformatf("dut%0d_abort_data", i), 64'(data_o[i]), 64'h0);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(4'd0, 32'd2, 32'd3, 0);

        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++)
            chk($sformatf("dut%0d_pending_results", i), 64'(exp_q[i].size()), 64'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
